// File: rtl/generic_bus_arbiter.sv
// Round-robin arbiter sharing one downstream generic bus port between NUM_REQ requesters.
// One transaction in flight at a time; a watchdog force-completes hung accesses with an error.
//
// state    | meaning
// ---------+------------------------------------------------------------
// S_IDLE   | no access in flight; pick next winner from ptr onwards
// S_ACCESS | grant_id owns the downstream port until busy drops or timeout
module generic_bus_arbiter #(
    parameter int NUM_REQ        = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                       CLK,
    input  logic                       nRST,
    input  logic [NUM_REQ-1:0]         req_ren,
    input  logic [NUM_REQ-1:0]         req_wen,
    input  logic [4*NUM_REQ-1:0]       req_byte_en,
    input  logic [32*NUM_REQ-1:0]      req_addr,
    input  logic [32*NUM_REQ-1:0]      req_wdata,
    output logic [NUM_REQ-1:0]         req_busy,
    output logic [31:0]                req_rdata,
    output logic [NUM_REQ-1:0]         req_error,
    output logic                       ren,
    output logic                       wen,
    output logic [3:0]                 byte_en,
    output logic [31:0]                addr,
    output logic [31:0]                wdata,
    input  logic                       busy,
    input  logic [31:0]                rdata,
    input  logic                       error,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       timeout
);
    localparam int IDW = $clog2(NUM_REQ);
    localparam int CW  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0]  WD_LAST = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [IDW-1:0] LAST_ID = IDW'(NUM_REQ - 1);

    typedef enum logic {S_IDLE, S_ACCESS} state_t;

    state_t           r_state, w_state_nxt;
    logic [IDW-1:0]   r_ptr, w_ptr_nxt;
    logic [IDW-1:0]   r_grant_id, w_grant_nxt;
    logic [CW-1:0]    r_wd_cnt, w_wd_nxt;
    logic [NUM_REQ-1:0] w_active;
    logic             w_found;
    logic [IDW-1:0]   w_winner;
    logic [IDW-1:0]   w_ptr_adv;
    logic             w_wd_fire;
    int               w_idx;

    assign w_active  = req_ren | req_wen;
    assign grant_id  = r_grant_id;
    assign w_ptr_adv = (r_grant_id == LAST_ID) ? '0 : r_grant_id + 1'b1;

    // Scan from the farthest offset back to ptr so the closest active index wins.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_idx    = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_idx = int'(r_ptr) + k;
            if (w_idx >= NUM_REQ) begin
                w_idx = w_idx - NUM_REQ;
            end
            if (w_active[w_idx]) begin
                w_found  = 1'b1;
                w_winner = IDW'(w_idx);
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_grant_nxt = r_grant_id;
        w_wd_nxt    = r_wd_cnt;
        w_wd_fire   = 1'b0;
        ren         = 1'b0;
        wen         = 1'b0;
        byte_en     = '0;
        addr        = '0;
        wdata       = '0;
        req_busy    = '1;
        req_error   = '0;
        req_rdata   = '0;
        timeout     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_grant_nxt = w_winner;
                    w_wd_nxt    = '0;
                    w_state_nxt = S_ACCESS;
                end
            end
            S_ACCESS: begin
                ren     = req_ren[r_grant_id];
                wen     = req_wen[r_grant_id];
                byte_en = req_byte_en[r_grant_id*4 +: 4];
                addr    = req_addr[r_grant_id*32 +: 32];
                wdata   = req_wdata[r_grant_id*32 +: 32];
                if ((TIMEOUT_CYCLES != 0) && busy && (r_wd_cnt == WD_LAST)) begin
                    w_wd_fire = 1'b1;
                end
                if (w_wd_fire) begin
                    req_busy[r_grant_id]  = 1'b0;
                    req_error[r_grant_id] = 1'b1;
                    timeout               = 1'b1;
                    w_state_nxt           = S_IDLE;
                    w_ptr_nxt             = w_ptr_adv;
                end else begin
                    req_busy[r_grant_id]  = busy;
                    req_error[r_grant_id] = error;
                    req_rdata             = rdata;
                    if (!busy) begin
                        w_state_nxt = S_IDLE;
                        w_ptr_nxt   = w_ptr_adv;
                    end else if (TIMEOUT_CYCLES != 0) begin
                        w_wd_nxt = r_wd_cnt + 1'b1;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state    <= S_IDLE;
            r_ptr      <= '0;
            r_grant_id <= '0;
            r_wd_cnt   <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_ptr      <= w_ptr_nxt;
            r_grant_id <= w_grant_nxt;
            r_wd_cnt   <= w_wd_nxt;
        end
    end
endmodule

// File: doc/generic_bus_arbiter.md
# generic_bus_arbiter

Round-robin arbiter that shares one downstream `generic_bus_if` port between `NUM_REQ` upstream requesters, such as per-hart instruction/data ports inside `multicore_wrapper`, before the core's single bus port. It serializes transactions, forwards exactly one requester's request at a time, and routes the completion back to that requester. A watchdog completes hung transactions with an error.

## Interface
Parameters:
- `NUM_REQ`, 2: number of upstream requesters, ≥2.
- `TIMEOUT_CYCLES`, 1024: consecutive downstream busy cycles before forced error completion; 0 disables the watchdog.

Ports:
- `CLK` in 1: clock.
- `nRST` in 1: asynchronous, active-low reset.
- `req_ren` in NUM_REQ: per-requester read request.
- `req_wen` in NUM_REQ: per-requester write request.
- `req_byte_en` in 4*NUM_REQ: per-requester byte enables, requester i at [4i+3:4i].
- `req_addr` in 32*NUM_REQ: per-requester address, requester i at [32i+31:32i].
- `req_wdata` in 32*NUM_REQ: per-requester write data, same packing as `req_addr`.
- `req_busy` out NUM_REQ: per-requester busy; 0 means that requester's transaction completes this cycle.
- `req_rdata` out 32: read data broadcast to all requesters; valid only to the requester whose `req_busy` is 0.
- `req_error` out NUM_REQ: per-requester error, valid in the completion cycle.
- `ren`, `wen` out 1: downstream request.
- `byte_en` out 4, `addr` out 32, `wdata` out 32: downstream request fields.
- `busy` in 1, `rdata` in 32, `error` in 1: downstream response.
- `grant_id` out $clog2(NUM_REQ): registered index of the current or last winner.
- `timeout` out 1: one-cycle pulse when the watchdog fires.

## Operation
- FSM states: IDLE and ACCESS. A registered round-robin pointer `ptr` holds the highest-priority index.
- IDLE
  - Active requesters are those with `req_ren|req_wen` high.
  - If any are active, the winner is the first active index searching ptr, ptr+1, … mod NUM_REQ.
  - On a winner: register it into `grant_id`, clear the watchdog counter, go to ACCESS.
  - All `req_busy`=1, `req_error`=0, downstream `ren`/`wen`=0.
- ACCESS
  - Downstream `ren`, `wen`, `byte_en`, `addr`, `wdata` are combinationally driven from requester `grant_id`.
  - Every non-granted requester sees `req_busy`=1 and `req_error`=0.
  - `req_busy[grant_id]` = `busy`, `req_error[grant_id]` = `error`, `req_rdata` = `rdata`.
  - Completion, when `busy`=0: next state IDLE, `ptr` ← (grant_id+1) mod NUM_REQ.
  - Watchdog, when TIMEOUT_CYCLES≠0: the counter increments on each ACCESS cycle with `busy`=1. In the cycle the counter equals TIMEOUT_CYCLES-1 with `busy` still 1:
    - force `req_busy[grant_id]`=0, `req_error[grant_id]`=1, `req_rdata`=0;
    - pulse `timeout`=1;
    - next state IDLE, `ptr` advances as on normal completion.
    - Any late downstream response is ignored.
- Protocol rules on requesters:
  - Hold request fields stable while their `req_busy`=1.
  - Do not assert `req_ren` and `req_wen` together.
  - If a granted requester drops its request mid-access, the arbiter still waits for downstream completion and that completion is discarded.
- Reset (async, any state): IDLE, `ptr`=0, `grant_id`=0, watchdog=0. Outputs: downstream `ren`=`wen`=0, `byte_en`=0, `addr`=0, `wdata`=0; `req_busy` all 1; `req_error` all 0; `req_rdata`=0; `timeout`=0.

## Timing
- Arbitration latency is 1 cycle. A request first seen in IDLE at cycle t appears downstream at t+1.
- Zero-wait slave (`busy`=0 at t+1): `req_busy[i]`=0 at t+1, IDLE at t+2.
- Minimum occupancy is 2 cycles per transaction, including the 1-cycle IDLE gap between back-to-back grants.
- A requester whose transaction completes in cycle c and re-requests in c+1 loses to any other active requester, because `ptr` has moved past it.
- With TIMEOUT_CYCLES=T and `busy` held at 1, the forced completion occurs in the T-th ACCESS cycle.
- `grant_id` holds its value through IDLE until the next grant.

## Test plan
- Single requester 0 reads addr 0x80000000, slave returns 0xDEADBEEF after 3 busy cycles -> `ren` high cycles t+1..t+4; `req_busy[0]`=0 with `req_rdata`=0xDEADBEEF at t+4; `req_busy[1]` stays 1 throughout.
- Requesters 0 and 1 request simultaneously from reset, continuously, zero-wait slave -> grants alternate 0,1,0,1 on consecutive ACCESS cycles, each followed by one IDLE cycle.
- NUM_REQ=4, requesters 1 and 3 active, ptr=2 -> grant 3, then grant 1.
- Write with `byte_en`=4'b0011, `wdata`=0x1234, slave `error`=1 at completion -> downstream sees exact fields; `req_error[i]`=1 only in the completion cycle.
- TIMEOUT_CYCLES=8, slave never drops `busy` -> in the 8th ACCESS cycle `timeout`=1, `req_error`=1, `req_rdata`=0; next cycle `ren`=0.
- Assert `nRST`=0 mid-ACCESS -> `ren`/`wen`=0 and all `req_busy`=1 immediately (asynchronously); after release, a new request is granted with `ptr`=0 priority.
